// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: one outstanding cache transaction, lane
// steering for stores, extension of load data, and misalignment detection.
module mem_access_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned BE_W  = XLEN / 8,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic              advance_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              rdata_valid_o,
    output logic              misalign_o,
    output logic              dmem_read_o,
    output logic              dmem_write_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [BE_W-1:0]   dmem_byte_en_o,
    input  logic              dmem_resp_i,
    input  logic [XLEN-1:0]   dmem_rdata_i
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_read;
    logic              r_write;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [BE_W-1:0]   r_be;
    logic [2:0]        r_funct3;
    logic [OFF_W-1:0]  r_off;
    logic              r_kill;
    logic [XLEN-1:0]   r_rdata;
    logic              r_rdata_valid;

    logic              w_access;
    logic              w_misalign;
    logic [OFF_W-1:0]  w_off;
    logic [BE_W-1:0]   w_base_be;
    logic [BE_W-1:0]   w_byte_en;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_addr;
    logic [XLEN-1:0]   w_load_ext;
    logic              w_latch;
    logic              w_resp;
    logic              w_capture;

    // Shift the addressed bytes down to bit 0, then sign/zero extend by size.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                    input logic [2:0]      f3,
                                                    input logic [OFF_W-1:0] off);
        logic [XLEN-1:0] t;
        int unsigned     sh;
        case (f3[1:0])
            2'b00:   sh = XLEN - 8;
            2'b01:   sh = XLEN - 16;
            2'b10:   sh = XLEN - 32;
            default: sh = 0;
        endcase
        t = (d >> {off, 3'b000}) << sh;
        if (f3[2])
            return t >> sh;
        else
            return $unsigned($signed(t) >>> sh);
    endfunction

    assign w_access   = valid_i & (mem_read_i | mem_write_i) & ~flush_i;
    assign w_off      = addr_i[OFF_W-1:0];
    assign w_byte_en  = w_base_be << w_off;
    assign w_wdata    = wdata_i << {w_off, 3'b000};
    assign w_addr     = {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign w_load_ext = extend_load(dmem_rdata_i, r_funct3, r_off);
    assign misalign_o = w_access & w_misalign;

    // Size decode; a dword in a 32-bit build can never be issued.
    always_comb begin
        w_misalign = 1'b0;
        w_base_be  = BE_W'(1);
        case (funct3_i[1:0])
            2'b00: begin
                w_misalign = 1'b0;
                w_base_be  = BE_W'(1);
            end
            2'b01: begin
                w_misalign = w_off[0];
                w_base_be  = BE_W'(3);
            end
            2'b10: begin
                w_misalign = |w_off[1:0];
                w_base_be  = BE_W'(15);
            end
            default: begin
                w_misalign = (XLEN == 32) ? 1'b1 : (|w_off);
                w_base_be  = {BE_W{1'b1}};
            end
        endcase
    end

    // Next state and stall; a response after a flush is swallowed.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_resp    = 1'b0;
        w_capture = 1'b0;
        stall_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && !w_misalign) begin
                    w_latch = 1'b1;
                    stall_o = 1'b1;
                    w_next  = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (dmem_resp_i) begin
                    w_resp = 1'b1;
                    if (r_kill || flush_i) begin
                        w_next = IDLE;
                    end else begin
                        w_next    = DONE;
                        w_capture = r_read;
                    end
                end
            end
            DONE: begin
                if (advance_i || flush_i)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_read        <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_be          <= '0;
            r_funct3      <= '0;
            r_off         <= '0;
            r_kill        <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_read   <= mem_read_i;
                r_write  <= mem_write_i;
                r_addr   <= w_addr;
                r_wdata  <= w_wdata;
                r_be     <= w_byte_en;
                r_funct3 <= funct3_i;
                r_off    <= w_off;
                r_kill   <= 1'b0;
            end
            if (r_state == BUSY && flush_i)
                r_kill <= 1'b1;
            if (w_resp) begin
                r_read  <= 1'b0;
                r_write <= 1'b0;
                r_kill  <= 1'b0;
            end
            if (w_capture) begin
                r_rdata       <= w_load_ext;
                r_rdata_valid <= 1'b1;
            end else if (r_state == DONE && w_next == IDLE) begin
                r_rdata_valid <= 1'b0;
            end
        end
    end

    assign rdata_o        = r_rdata;
    assign rdata_valid_o  = r_rdata_valid;
    assign dmem_read_o    = r_read;
    assign dmem_write_o   = r_write;
    assign dmem_addr_o    = r_addr;
    assign dmem_wdata_o   = r_wdata;
    assign dmem_byte_en_o = r_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: 32-bit and 64-bit instances on one clock.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 32-bit instance signals
    logic        v32 = 0, rd32 = 0, wr32 = 0, adv32 = 0, fl32 = 0, resp32 = 0;
    logic [2:0]  f3_32 = 0;
    logic [31:0] addr32 = 0, wd32 = 0, rdin32 = 0;
    logic        stall32, rvalid32, mis32, drd32, dwr32;
    logic [31:0] rdata32, daddr32, dwd32;
    logic [3:0]  be32;

    // 64-bit instance signals
    logic        v64 = 0, rd64 = 0, wr64 = 0, adv64 = 0, fl64 = 0, resp64 = 0;
    logic [2:0]  f3_64 = 0;
    logic [63:0] addr64 = 0, wd64 = 0, rdin64 = 0;
    logic        stall64, rvalid64, mis64, drd64, dwr64;
    logic [63:0] rdata64, daddr64, dwd64;
    logic [7:0]  be64;

    mem_access_unit #(.XLEN(32)) u32 (
        .clk(clk), .rst(rst), .valid_i(v32), .mem_read_i(rd32), .mem_write_i(wr32),
        .funct3_i(f3_32), .addr_i(addr32), .wdata_i(wd32), .advance_i(adv32),
        .flush_i(fl32), .stall_o(stall32), .rdata_o(rdata32), .rdata_valid_o(rvalid32),
        .misalign_o(mis32), .dmem_read_o(drd32), .dmem_write_o(dwr32),
        .dmem_addr_o(daddr32), .dmem_wdata_o(dwd32), .dmem_byte_en_o(be32),
        .dmem_resp_i(resp32), .dmem_rdata_i(rdin32)
    );

    mem_access_unit #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .valid_i(v64), .mem_read_i(rd64), .mem_write_i(wr64),
        .funct3_i(f3_64), .addr_i(addr64), .wdata_i(wd64), .advance_i(adv64),
        .flush_i(fl64), .stall_o(stall64), .rdata_o(rdata64), .rdata_valid_o(rvalid64),
        .misalign_o(mis64), .dmem_read_o(drd64), .dmem_write_o(dwr64),
        .dmem_addr_o(daddr64), .dmem_wdata_o(dwd64), .dmem_byte_en_o(be64),
        .dmem_resp_i(resp64), .dmem_rdata_i(rdin64)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        tick();
        tick();
        check("rst_stall", 64'(stall32), 64'd0);
        check("rst_read", 64'(drd32), 64'd0);
        check("rst_rvalid", 64'(rvalid32), 64'd0);
        check("rst_rdata", 64'(rdata32), 64'd0);
        check("rst_addr", 64'(daddr32), 64'd0);
        check("rst_be64", 64'(be64), 64'd0);
        rst = 1'b1;
        tick();

        // LB at 0x1003, one-cycle cache
        v32 = 1; rd32 = 1; f3_32 = 3'b000; addr32 = 32'h1003;
        #1;
        check("lb_stall_c1", 64'(stall32), 64'd1);
        check("lb_mis", 64'(mis32), 64'd0);
        check("lb_noreq_c1", 64'(drd32), 64'd0);
        tick();
        check("lb_stall_c2", 64'(stall32), 64'd1);
        check("lb_read", 64'(drd32), 64'd1);
        check("lb_addr", 64'(daddr32), 64'h1000);
        check("lb_be", 64'(be32), 64'h8);
        resp32 = 1; rdin32 = 32'h80FF_FF00;
        tick();
        resp32 = 0;
        check("lb_stall_c3", 64'(stall32), 64'd0);
        check("lb_rvalid", 64'(rvalid32), 64'd1);
        check("lb_rdata", 64'(rdata32), 64'hFFFF_FF80);
        check("lb_req_drop", 64'(drd32), 64'd0);
        tick();
        check("lb_hold_rvalid", 64'(rvalid32), 64'd1);
        check("lb_hold_stall", 64'(stall32), 64'd0);
        adv32 = 1;
        tick();
        adv32 = 0; v32 = 0; rd32 = 0;
        #1;
        check("lb_adv_rvalid", 64'(rvalid32), 64'd0);
        check("lb_adv_stall", 64'(stall32), 64'd0);

        // LHU at 0x2002, three-cycle cache
        v32 = 1; rd32 = 1; f3_32 = 3'b101; addr32 = 32'h2002;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lhu_read", 64'(drd32), 64'd1);
            check("lhu_addr", 64'(daddr32), 64'h2000);
            check("lhu_be", 64'(be32), 64'hC);
            check("lhu_stall", 64'(stall32), 64'd1);
            if (i == 2) begin
                resp32 = 1; rdin32 = 32'h8001_1234;
            end
            tick();
        end
        resp32 = 0;
        check("lhu_rdata", 64'(rdata32), 64'h0000_8001);
        check("lhu_rvalid", 64'(rvalid32), 64'd1);
        adv32 = 1;
        tick();
        adv32 = 0; v32 = 0; rd32 = 0;

        // SB at 0x3001
        v32 = 1; wr32 = 1; f3_32 = 3'b000; addr32 = 32'h3001; wd32 = 32'h0000_00AB;
        tick();
        check("sb_write", 64'(dwr32), 64'd1);
        check("sb_read", 64'(drd32), 64'd0);
        check("sb_be", 64'(be32), 64'h2);
        check("sb_wdata", 64'(dwd32), 64'h0000_AB00);
        check("sb_addr", 64'(daddr32), 64'h3000);
        resp32 = 1;
        tick();
        resp32 = 0;
        check("sb_rvalid", 64'(rvalid32), 64'd0);
        check("sb_stall", 64'(stall32), 64'd0);
        check("sb_wr_drop", 64'(dwr32), 64'd0);
        adv32 = 1;
        tick();
        adv32 = 0; v32 = 0; wr32 = 0;

        // Misaligned LW at 0x4002; a stray response in IDLE must be ignored
        v32 = 1; rd32 = 1; f3_32 = 3'b010; addr32 = 32'h4002; resp32 = 1;
        #1;
        check("lw_mis", 64'(mis32), 64'd1);
        check("lw_mis_stall", 64'(stall32), 64'd0);
        tick();
        check("lw_mis_noreq", 64'(drd32), 64'd0);
        check("lw_mis_rvalid", 64'(rvalid32), 64'd0);
        resp32 = 0;
        f3_32 = 3'b011; addr32 = 32'h6000;
        #1;
        check("ld32_mis", 64'(mis32), 64'd1);
        v32 = 0; rd32 = 0;
        #1;
        check("mis_gated", 64'(mis32), 64'd0);

        // Flush during BUSY: request completes, result discarded
        v32 = 1; rd32 = 1; f3_32 = 3'b010; addr32 = 32'h5000;
        tick();
        fl32 = 1; v32 = 0; rd32 = 0;
        #1;
        check("fl_stall_b1", 64'(stall32), 64'd1);
        tick();
        fl32 = 0;
        check("fl_stall_b2", 64'(stall32), 64'd1);
        check("fl_read_held", 64'(drd32), 64'd1);
        resp32 = 1; rdin32 = 32'h1234_5678;
        #1;
        check("fl_stall_resp", 64'(stall32), 64'd1);
        tick();
        resp32 = 0;
        check("fl_rvalid", 64'(rvalid32), 64'd0);
        check("fl_stall_idle", 64'(stall32), 64'd0);
        check("fl_req_drop", 64'(drd32), 64'd0);
        // Back in IDLE: a new LBU is accepted immediately
        v32 = 1; rd32 = 1; f3_32 = 3'b100; addr32 = 32'h5001;
        #1;
        check("lbu_accept", 64'(stall32), 64'd1);
        tick();
        check("lbu_be", 64'(be32), 64'h2);
        resp32 = 1; rdin32 = 32'h0000_C300;
        tick();
        resp32 = 0;
        check("lbu_rdata", 64'(rdata32), 64'h0000_00C3);
        adv32 = 1;
        tick();
        adv32 = 0; v32 = 0; rd32 = 0;

        // 64-bit LWU at offset 4
        v64 = 1; rd64 = 1; f3_64 = 3'b110; addr64 = 64'h0000_0000_0000_1004;
        tick();
        check("lwu_addr", daddr64, 64'h1000);
        check("lwu_be", 64'(be64), 64'hF0);
        resp64 = 1; rdin64 = 64'hF000_0001_1234_5678;
        tick();
        resp64 = 0;
        check("lwu_rdata", rdata64, 64'h0000_0000_F000_0001);
        check("lwu_rvalid", 64'(rvalid64), 64'd1);
        adv64 = 1;
        tick();
        adv64 = 0; v64 = 0; rd64 = 0;

        // 64-bit LD, reset mid-BUSY
        v64 = 1; rd64 = 1; f3_64 = 3'b011; addr64 = 64'h0000_0000_0000_2000;
        tick();
        check("ld_read", 64'(drd64), 64'd1);
        check("ld_be", 64'(be64), 64'hFF);
        rst = 0; v64 = 0; rd64 = 0;
        tick();
        rst = 1;
        check("rst_busy_read", 64'(drd64), 64'd0);
        check("rst_busy_stall", 64'(stall64), 64'd0);
        resp64 = 1;
        tick();
        resp64 = 0;
        check("rst_resp_ignored", 64'(rvalid64), 64'd0);
        check("rst_resp_rdata", rdata64, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised pipeline memory-stage access unit that replaces the purely combinational MEM-stage address/byte-enable logic.
- Sits between the EX/MEM pipeline register and the data-cache port.
- Owns one in-flight data-memory transaction at a time.
- Generates aligned requests, byte enables and shifted store data, and stalls the pipeline until the cache responds.
- Returns sign- or zero-extended load data, and flags misaligned accesses instead of issuing them.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
BE_W, XLEN/8, byte-enable width.
OFF_W, $clog2(XLEN/8), byte-offset bits of the address.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous, active-low reset.
valid_i  in  1  MEM stage holds a live instruction.
mem_read_i  in  1  instruction is a load.
mem_write_i  in  1  instruction is a store.
funct3_i  in  3  RISC-V load/store funct3.
addr_i  in  XLEN  effective address (ALU result).
wdata_i  in  XLEN  store data, already forwarded.
advance_i  in  1  MEM/WB register latches this cycle.
flush_i  in  1  kill the current MEM-stage instruction.
stall_o  out  1  hold all upstream pipeline registers.
rdata_o  out  XLEN  extended load result.
rdata_valid_o  out  1  rdata_o holds the current load's result.
misalign_o  out  1  current access is misaligned; no request is issued.
dmem_read_o  out  1  cache read request.
dmem_write_o  out  1  cache write request.
dmem_addr_o  out  XLEN  address with low OFF_W bits forced to 0.
dmem_wdata_o  out  XLEN  store data shifted into byte lanes.
dmem_byte_en_o  out  BE_W  byte-lane enables.
dmem_resp_i  in  1  cache completion pulse.
dmem_rdata_i  in  XLEN  cache read data, valid with dmem_resp_i.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - All registered outputs 0.
  - Any outstanding cache response is ignored.
- Access decode:
  - access = valid_i & (mem_read_i | mem_write_i) & ~flush_i.
  - off = addr_i[OFF_W-1:0].
  - size from funct3[1:0]: 00 byte, 01 half, 10 word, 11 dword.
  - Dword is legal only when XLEN=64. In a 32-bit build, funct3[1:0]=11 is treated as misaligned.
- Misalignment:
  - Condition: half with off[0]≠0; word with off[1:0]≠0; dword with off[2:0]≠0.
  - misalign_o is combinational.
  - No request is issued, stall_o=0, state stays IDLE.
- Store lanes:
  - byte_en = base mask << off, where base mask is byte 0x1, half 0x3, word 0xF, dword 0xFF.
  - wdata shifted left by 8*off.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On access & ~misalign, latch the aligned address, shifted wdata, byte_en, read/write, funct3 and off into registers. Next state BUSY.
  - stall_o=1 combinationally in that same cycle.
- BUSY:
  - dmem_read_o/dmem_write_o driven from registers and held stable with address, data and byte-enables until dmem_resp_i.
  - stall_o=1.
  - On dmem_resp_i:
    - Deassert the request on the next edge.
    - For loads, capture the extended result into rdata_o: dmem_rdata_i shifted right by 8*off, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) from the access size.
    - Next state DONE.
  - A response arriving in the first BUSY cycle is legal: one-cycle cache.
- DONE:
  - stall_o=0.
  - rdata_valid_o=1 for loads, 0 for stores.
  - On advance_i, next state IDLE and rdata_valid_o cleared.
  - Without advance_i, stay in DONE, holding the result indefinitely; no re-issue.
- flush_i:
  - In IDLE, it suppresses the access.
  - In BUSY, the request is not aborted. stall_o stays 1 until dmem_resp_i, then the result is discarded and next state is IDLE, not DONE.
  - In DONE, next state IDLE and rdata_valid_o cleared.
- dmem_resp_i while in IDLE or DONE is ignored.
- Latency: a load with a 1-cycle cache stalls 2 cycles, and the result is valid in cycle 3.

Test Plan:
- XLEN=32, LB (funct3=000), addr=0x1003, cache returns 0x80FF_FF00 after 1 cycle -> dmem_addr_o=0x1000, byte_en=0x8, rdata_o=0xFFFF_FF80, stall high exactly 2 cycles.
- LHU (101), addr=0x2002, rdata=0x8001_1234 with 3-cycle latency -> byte_en=0xC, rdata_o=0x0000_8001, request signals stable all BUSY cycles.
- SB (000), addr=0x3001, wdata_i=0x0000_00AB -> dmem_write_o=1, byte_en=0x2, dmem_wdata_o=0x0000_AB00, rdata_valid_o=0 in DONE.
- LW at addr=0x4002 -> misalign_o=1, no dmem_read_o, stall_o=0, state stays IDLE.
- Load in BUSY, flush_i pulsed, response 2 cycles later -> stall held until response, rdata_valid_o never asserted, state returns to IDLE.
- XLEN=64, LWU (110), addr=0x..04, rdata=0xF000_0001_xxxx_xxxx -> rdata_o=0x0000_0000_F000_0001. Reset asserted mid-BUSY -> state IDLE and dmem_read_o=0 next cycle.
